// File: rtl/ccff_readback.sv
// ccff_readback: reads the configuration chain back through one full rotation, recirculating tail to head, and packs the bits into words.
// Optional build macro READBACK_CRC_EN adds a CRC-16-CCITT over the captured bits on the crc port. Rev 1.0
`default_nettype none

module ccff_readback #(
  parameter int CHAIN_LEN = 88,
  parameter int WORD_W    = 8
) (
  input  logic              prog_clk,
  input  logic              pReset_n,
  input  logic              start,
  input  logic              ccff_tail,
  output logic              ccff_head,
  output logic              ccff_shift_en,
  output logic [WORD_W-1:0] rd_data,
  output logic              rd_valid,
  input  logic              rd_ready,
  output logic              rd_last,
  output logic              busy,
  output logic              done
`ifdef READBACK_CRC_EN
  ,
  output logic [15:0]       crc
`endif
);

  localparam int CNT_W = $clog2(CHAIN_LEN + 1);
  localparam int IDX_W = (WORD_W > 1) ? $clog2(WORD_W) : 1;

  localparam logic [CNT_W-1:0] C_LAST_BIT = CNT_W'(CHAIN_LEN - 1);
  localparam logic [IDX_W-1:0] C_LAST_IDX = IDX_W'(WORD_W - 1);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_SHIFT = 2'd1;
  localparam logic [1:0] S_DRAIN = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  logic [1:0]        r_state;
  logic [CNT_W-1:0]  r_bit_cnt;
  logic [IDX_W-1:0]  r_idx;
  logic [WORD_W-1:0] r_acc;
  logic [WORD_W-1:0] r_rd_data;
  logic              r_rd_valid;
  logic              r_rd_last;

  logic              w_last_bit;
  logic              w_word_done;
  logic              w_stall;
  logic              w_capture;
  logic [WORD_W-1:0] w_word;

  // The chain head always takes the tail so a full rotation restores the bitstream.
  assign ccff_head = ccff_tail;

  assign w_last_bit  = (r_bit_cnt == C_LAST_BIT);
  assign w_word_done = (r_idx == C_LAST_IDX) | w_last_bit;
  assign w_stall     = w_word_done & r_rd_valid & ~rd_ready;
  assign w_capture   = (r_state == S_SHIFT) & ~w_stall;

  // Accumulator is cleared after each word, so bits above the index are already zero padding.
  always_comb begin
    w_word        = r_acc;
    w_word[r_idx] = ccff_tail;
  end

  always_ff @(posedge prog_clk or negedge pReset_n) begin
    if (!pReset_n) begin
      r_state   <= S_IDLE;
      r_bit_cnt <= '0;
      r_idx     <= '0;
      r_acc     <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_state   <= S_SHIFT;
            r_bit_cnt <= '0;
            r_idx     <= '0;
            r_acc     <= '0;
          end
        end
        S_SHIFT: begin
          if (w_capture) begin
            r_bit_cnt <= r_bit_cnt + 1'b1;
            if (w_word_done) begin
              r_idx <= '0;
              r_acc <= '0;
            end else begin
              r_idx <= r_idx + 1'b1;
              r_acc <= w_word;
            end
            if (w_last_bit) begin
              r_state <= S_DRAIN;
            end
          end
        end
        S_DRAIN: begin
          if (r_rd_valid && rd_ready) begin
            r_state <= S_DONE;
          end
        end
        S_DONE: begin
          r_state <= S_IDLE;
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  // A word loading on the same edge as an acceptance keeps rd_valid high with the new data.
  always_ff @(posedge prog_clk or negedge pReset_n) begin
    if (!pReset_n) begin
      r_rd_data  <= '0;
      r_rd_valid <= 1'b0;
      r_rd_last  <= 1'b0;
    end else if (w_capture && w_word_done) begin
      r_rd_data  <= w_word;
      r_rd_valid <= 1'b1;
      r_rd_last  <= w_last_bit;
    end else if (rd_ready) begin
      r_rd_valid <= 1'b0;
    end
  end

`ifdef READBACK_CRC_EN
  logic [15:0] r_crc;
  logic        w_crc_fb;

  assign w_crc_fb = r_crc[15] ^ ccff_tail;

  always_ff @(posedge prog_clk or negedge pReset_n) begin
    if (!pReset_n) begin
      r_crc <= '0;
    end else if (r_state == S_IDLE && start) begin
      r_crc <= 16'hFFFF;
    end else if (w_capture) begin
      r_crc <= {r_crc[14:0], 1'b0} ^ (w_crc_fb ? 16'h1021 : 16'h0000);
    end
  end

  assign crc = r_crc;
`endif

  assign ccff_shift_en = w_capture;
  assign rd_data       = r_rd_data;
  assign rd_valid      = r_rd_valid;
  assign rd_last       = r_rd_last;
  assign busy          = (r_state != S_IDLE);
  assign done          = (r_state == S_DONE);

endmodule

`default_nettype wire
